// File: rtl/iir_cfg_sequencer_pkg.sv
// Shared definitions for the IIR configuration sequencer: stream layout,
// FSM state encoding and stream-position index helpers.
package iir_cfg_sequencer_pkg;

  localparam int unsigned COEF_PER_SEC  = 6;
  localparam int unsigned WORDS_PER_SEC = COEF_PER_SEC + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_SMP,
    FLUSH
  } state_t;

  // Stream: scale[0], then per section c0..c5 followed by scale[k+1].
  function automatic int unsigned total_words(input int unsigned nsec);
    return WORDS_PER_SEC * nsec + 1;
  endfunction

  function automatic logic pos_is_scale(input int unsigned pos);
    return (pos % WORDS_PER_SEC) == 0;
  endfunction

  function automatic int unsigned pos_scale_slot(input int unsigned pos);
    return pos / WORDS_PER_SEC;
  endfunction

  // Flat coefficient index (6*section + coef); only meaningful for non-scale positions.
  function automatic int unsigned pos_coef_slot(input int unsigned pos);
    return (pos / WORDS_PER_SEC) * COEF_PER_SEC + (pos % WORDS_PER_SEC) - 1;
  endfunction

endpackage

// File: rtl/iir_cfg_sequencer_if.sv
// Valid/ready configuration word stream into the sequencer.
interface iir_cfg_sequencer_if #(
  parameter int unsigned WS = 16
) ();
  logic          cfg_valid;
  logic [WS-1:0] cfg_data;
  logic          cfg_last;
  logic          cfg_ready;

  modport master (output cfg_valid, cfg_data, cfg_last, input cfg_ready);
  modport slave  (input cfg_valid, cfg_data, cfg_last, output cfg_ready);
endinterface

// File: rtl/iir_cfg_bank.sv
// Shadow/active coefficient and scale register pair: stream-position write
// port into the shadow bank, whole-bank copy to active on commit.
module iir_cfg_bank
  import iir_cfg_sequencer_pkg::*;
#(
  parameter int unsigned NSEC = 1,
  parameter int unsigned WC   = 10,
  parameter int unsigned WS   = 16,
  parameter int unsigned CW   = 4
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                wr_en,
  input  logic [CW-1:0]                       wr_pos,
  input  logic [WS-1:0]                       wr_data,
  input  logic                                commit,
  output logic [COEF_PER_SEC*NSEC*WC-1:0]     coef_flat,
  output logic [(NSEC+1)*WS-1:0]              scale_flat
);

  localparam int unsigned NCOEF  = COEF_PER_SEC * NSEC;
  localparam int unsigned NSCALE = NSEC + 1;

  logic [WC-1:0] sh_coef  [NCOEF];
  logic [WC-1:0] act_coef [NCOEF];
  logic [WS-1:0] sh_scale [NSCALE];
  logic [WS-1:0] act_scale[NSCALE];

  int unsigned pos;
  logic        is_scale;
  int unsigned scale_slot;
  int unsigned coef_slot;

  always_comb begin
    pos        = {{(32-CW){1'b0}}, wr_pos};
    is_scale   = pos_is_scale(pos);
    scale_slot = pos_scale_slot(pos);
    coef_slot  = pos_coef_slot(pos);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < NCOEF; i++) begin
        sh_coef[i]  <= '0;
        act_coef[i] <= '0;
      end
      for (int unsigned i = 0; i < NSCALE; i++) begin
        sh_scale[i]  <= '0;
        act_scale[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        if (is_scale) sh_scale[scale_slot] <= wr_data;
        else          sh_coef[coef_slot]   <= wr_data[WC-1:0];
      end
      if (commit) begin
        for (int unsigned i = 0; i < NCOEF; i++)  act_coef[i]  <= sh_coef[i];
        for (int unsigned i = 0; i < NSCALE; i++) act_scale[i] <= sh_scale[i];
      end
    end
  end

  always_comb begin
    coef_flat  = '0;
    scale_flat = '0;
    for (int unsigned i = 0; i < NCOEF; i++)  coef_flat[i*WC +: WC]  = act_coef[i];
    for (int unsigned i = 0; i < NSCALE; i++) scale_flat[i*WS +: WS] = act_scale[i];
  end

endmodule

// File: rtl/iir_cfg_sequencer.sv
// Configuration controller for the cascaded-SOS IIR: loads a shadow bank over
// a valid/ready stream, commits it on a sample boundary, then flushes the filter.
module iir_cfg_sequencer
  import iir_cfg_sequencer_pkg::*;
#(
  parameter int unsigned NSEC      = 1,
  parameter int unsigned WC        = 10,
  parameter int unsigned WS        = 16,
  parameter int unsigned FLUSH_CYC = 4
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            ce_in,
  input  logic                            sample_strobe,
  input  logic                            load_req,
  iir_cfg_sequencer_if.slave              cfg,
  output logic [COEF_PER_SEC*NSEC*WC-1:0] coef_flat,
  output logic [(NSEC+1)*WS-1:0]          scale_flat,
  output logic                            filt_ce,
  output logic                            filt_rst_n,
  output logic                            busy,
  output logic                            loaded,
  output logic                            done,
  output logic                            err
);

  localparam int unsigned   TOTAL    = total_words(NSEC);
  localparam int unsigned   CW       = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST_POS = CW'(TOTAL - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [7:0]    flush_cnt;

  logic accept, at_last, good_end, bad_end, commit, flush_end;

  always_comb begin
    accept    = (state == LOAD) && cfg.cfg_valid;
    at_last   = (cnt == LAST_POS);
    good_end  = accept && cfg.cfg_last && at_last;
    // Early last or missing last at the final position both abort the load.
    bad_end   = accept && (cfg.cfg_last != at_last);
    commit    = (state == WAIT_SMP) && sample_strobe;
    flush_end = (state == FLUSH) && (flush_cnt <= 8'd1);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      flush_cnt <= '0;
      loaded    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= flush_end;
      err   <= bad_end;
      if ((state == IDLE) && load_req) cnt <= '0;
      else if (accept)                 cnt <= cnt + 1'b1;
      if (commit)              flush_cnt <= 8'(FLUSH_CYC);
      else if (state == FLUSH) flush_cnt <= flush_cnt - 8'd1;
      if (commit) loaded <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (load_req) state_nxt = LOAD;
      LOAD: begin
        if (good_end)     state_nxt = WAIT_SMP;
        else if (bad_end) state_nxt = IDLE;
      end
      WAIT_SMP: if (sample_strobe) state_nxt = FLUSH;
      FLUSH:    if (flush_end) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg.cfg_ready = (state == LOAD);
    busy          = (state != IDLE);
    filt_ce       = ce_in && loaded && (state != FLUSH);
    filt_rst_n    = loaded && (state != FLUSH);
  end

  iir_cfg_bank #(
    .NSEC (NSEC),
    .WC   (WC),
    .WS   (WS),
    .CW   (CW)
  ) u_bank (
    .CLK        (CLK),
    .RESET      (RESET),
    .wr_en      (accept),
    .wr_pos     (cnt),
    .wr_data    (cfg.cfg_data),
    .commit     (commit),
    .coef_flat  (coef_flat),
    .scale_flat (scale_flat)
  );

endmodule

// File: tb/tb_iir_cfg_sequencer.sv
// Directed-sequence bench for iir_cfg_sequencer with randomized words and a
// behavioural shadow/active bank model.
module tb_iir_cfg_sequencer;

  localparam int unsigned NSEC      = 1;
  localparam int unsigned WC        = 10;
  localparam int unsigned WS        = 16;
  localparam int unsigned FLUSH_CYC = 4;
  localparam int unsigned NCOEF     = 6 * NSEC;
  localparam int unsigned NSCALE    = NSEC + 1;
  localparam int unsigned TOTAL     = 7 * NSEC + 1;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESET, ce_in, sample_strobe, load_req;
  logic [NCOEF*WC-1:0]  coef_flat;
  logic [NSCALE*WS-1:0] scale_flat;
  logic filt_ce, filt_rst_n, busy, loaded, done, err;

  iir_cfg_sequencer_if #(.WS(WS)) cfg_if ();

  iir_cfg_sequencer #(
    .NSEC      (NSEC),
    .WC        (WC),
    .WS        (WS),
    .FLUSH_CYC (FLUSH_CYC)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .ce_in         (ce_in),
    .sample_strobe (sample_strobe),
    .load_req      (load_req),
    .cfg           (cfg_if.slave),
    .coef_flat     (coef_flat),
    .scale_flat    (scale_flat),
    .filt_ce       (filt_ce),
    .filt_rst_n    (filt_rst_n),
    .busy          (busy),
    .loaded        (loaded),
    .done          (done),
    .err           (err)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [WC-1:0] m_sh_coef [NCOEF];
  logic [WC-1:0] m_act_coef[NCOEF];
  logic [WS-1:0] m_sh_scale [NSCALE];
  logic [WS-1:0] m_act_scale[NSCALE];
  logic          m_loaded;
  logic [WS-1:0] words[TOTAL];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int unsigned i = 0; i < NCOEF; i++) begin
      m_sh_coef[i] = '0; m_act_coef[i] = '0;
    end
    for (int unsigned i = 0; i < NSCALE; i++) begin
      m_sh_scale[i] = '0; m_act_scale[i] = '0;
    end
    m_loaded = 1'b0;
  endtask

  // Position p: p==0 -> scale 0; else section (p-1)/7, offset (p-1)%7 (6 -> trailing scale).
  task automatic model_store(input int unsigned p, input logic [WS-1:0] d);
    int unsigned k, r;
    if (p == 0) m_sh_scale[0] = d;
    else begin
      k = (p - 1) / 7;
      r = (p - 1) % 7;
      if (r < 6) m_sh_coef[k*6 + r] = d[WC-1:0];
      else       m_sh_scale[k+1]    = d;
    end
  endtask

  task automatic model_commit();
    for (int unsigned i = 0; i < NCOEF; i++)  m_act_coef[i]  = m_sh_coef[i];
    for (int unsigned i = 0; i < NSCALE; i++) m_act_scale[i] = m_sh_scale[i];
    m_loaded = 1'b1;
  endtask

  function automatic logic [63:0] exp_coef();
    logic [NCOEF*WC-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NCOEF; i++) v[i*WC +: WC] = m_act_coef[i];
    return 64'(v);
  endfunction

  function automatic logic [63:0] exp_scale();
    logic [NSCALE*WS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NSCALE; i++) v[i*WS +: WS] = m_act_scale[i];
    return 64'(v);
  endfunction

  task automatic check_bank(input string tag);
    check({tag, "_coef"},   64'(coef_flat),  exp_coef());
    check({tag, "_scale"},  64'(scale_flat), exp_scale());
    check({tag, "_loaded"}, 64'(loaded),     64'(m_loaded));
  endtask

  task automatic check_reset(input string tag);
    check_bank(tag);
    check({tag, "_busy"},  64'(busy),          64'd0);
    check({tag, "_done"},  64'(done),          64'd0);
    check({tag, "_err"},   64'(err),           64'd0);
    check({tag, "_ready"}, 64'(cfg_if.cfg_ready), 64'd0);
    check({tag, "_frst"},  64'(filt_rst_n),    64'd0);
    check({tag, "_fce"},   64'(filt_ce),       64'd0);
  endtask

  task automatic fill_random();
    for (int unsigned i = 0; i < TOTAL; i++) words[i] = WS'($urandom);
  endtask

  // Enter LOAD; a word offered in the load_req cycle must be refused.
  task automatic start_load(input string tag);
    load_req         = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 16'hdead;
    cfg_if.cfg_last  = 1'b1;
    #1;
    check({tag, "_idle_ready"}, 64'(cfg_if.cfg_ready), 64'd0);
    tick();
    load_req         = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_last  = 1'b0;
    check({tag, "_load_busy"}, 64'(busy), 64'd1);
    check({tag, "_load_err"},  64'(err),  64'd0);
  endtask

  task automatic send(input string tag, input int unsigned n, input int unsigned last_at, input bit bp);
    for (int unsigned i = 0; i < n; i++) begin
      if (bp) begin
        for (int unsigned g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
          cfg_if.cfg_valid = 1'b0;
          cfg_if.cfg_data  = WS'($urandom);
          cfg_if.cfg_last  = 1'($urandom);
          load_req         = 1'($urandom);
          tick();
        end
      end
      load_req         = 1'b0;
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_data  = words[i];
      cfg_if.cfg_last  = (i + 1 == last_at);
      #1;
      check({tag, "_ready"}, 64'(cfg_if.cfg_ready), 64'd1);
      model_store(i, words[i]);
      tick();
    end
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_last  = 1'b0;
    load_req         = 1'b0;
  endtask

  task automatic commit_and_flush(input string tag);
    int unsigned lowcnt;
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    model_commit();
    check_bank({tag, "_commit"});
    check({tag, "_flush_frst"}, 64'(filt_rst_n), 64'd0);
    check({tag, "_flush_fce"},  64'(filt_ce),    64'd0);
    lowcnt = 1;
    for (int unsigned i = 0; i < 64 && filt_rst_n === 1'b0; i++) begin
      tick();
      if (filt_rst_n === 1'b0) lowcnt++;
    end
    check({tag, "_flush_len"},  64'(lowcnt),     64'(FLUSH_CYC));
    check({tag, "_done"},       64'(done),       64'd1);
    check({tag, "_idle_busy"},  64'(busy),       64'd0);
    check({tag, "_after_frst"}, 64'(filt_rst_n), 64'(m_loaded));
    tick();
    check({tag, "_done_pulse"}, 64'(done),       64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WS-1:0] base_words[TOTAL];
    RESET = 1'b0; ce_in = 1'b1; sample_strobe = 1'b0; load_req = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_data = '0; cfg_if.cfg_last = 1'b0;
    model_reset();
    repeat (3) tick();
    check_reset("reset");
    RESET = 1'b1;
    tick();

    // Basic load: scale0=0x800, c0..c5 = 1..6 with junk in the upper bits, scale1=0x400.
    base_words[0] = 16'h0800;
    for (int unsigned i = 1; i <= 6; i++) base_words[i] = WS'(i) | 16'hfc00;
    base_words[7] = 16'h0400;
    words = base_words;
    start_load("t1");
    send("t1", TOTAL, TOTAL, 1'b0);
    check("t1_wait_busy",  64'(busy),              64'd1);
    check("t1_wait_ready", 64'(cfg_if.cfg_ready),  64'd0);
    check_bank("t1_wait");
    repeat (2) tick();
    commit_and_flush("t1");
    check("t1_scale_lit", 64'(scale_flat), 64'h0000_0000_0400_0800);
    for (int unsigned j = 0; j < 6; j++) check("t1_coef_lit", 64'(coef_flat[j*WC +: WC]), 64'(j + 1));

    // Early last on word 5 aborts; active bank untouched.
    fill_random();
    start_load("t2");
    send("t2", 5, 5, 1'b0);
    check("t2_err",  64'(err),  64'd1);
    check("t2_busy", 64'(busy), 64'd0);
    check_bank("t2");
    tick();
    check("t2_err_pulse", 64'(err), 64'd0);

    // Full length without last aborts.
    fill_random();
    start_load("t3");
    send("t3", TOTAL, 0, 1'b0);
    check("t3_err",  64'(err),  64'd1);
    check("t3_busy", 64'(busy), 64'd0);
    check_bank("t3");
    tick();

    // Strobe in IDLE is ignored; then a load held in WAIT_SMP for 20 cycles.
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    check("t4_idle_strobe_busy", 64'(busy), 64'd0);
    check_bank("t4_idle_strobe");
    fill_random();
    start_load("t4");
    send("t4", TOTAL, TOTAL, 1'b0);
    for (int unsigned c = 0; c < 20; c++) begin
      ce_in = 1'($urandom);
      #1;
      check("t4_wait_fce", 64'(filt_ce), 64'(ce_in && m_loaded));
      check_bank("t4_wait");
      tick();
    end
    ce_in = 1'b1;
    commit_and_flush("t4");

    // Back-pressure with the first test's words gives the first test's result.
    words = base_words;
    start_load("t5");
    send("t5", TOTAL, TOTAL, 1'b1);
    check("t5_wait_busy", 64'(busy), 64'd1);
    commit_and_flush("t5");
    check("t5_scale_lit", 64'(scale_flat), 64'h0000_0000_0400_0800);

    // Reset during the second flush cycle.
    fill_random();
    start_load("t6");
    send("t6", TOTAL, TOTAL, 1'b0);
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    tick();
    RESET = 1'b0;
    tick();
    model_reset();
    check_reset("t6_reset");
    RESET = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
